// File: rtl/seq_mult_pkg.sv
// Shared FSM state encoding and WIDTH legality limits for seq_mult.
// FIX state is present only when SEQ_MULT_SIGNED_EN is defined.
package seq_mult_pkg;

    localparam int unsigned WIDTH_MIN = 2;
    localparam int unsigned WIDTH_MAX = 16;

`ifdef SEQ_MULT_SIGNED_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd3
    } state_t;
`endif

endpackage

// File: rtl/seq_mult_if.sv
// Request/result bundle between a multiply requester (master) and seq_mult (slave).
interface seq_mult_if #(
    parameter int unsigned WIDTH = 4
);
    logic               start;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;

    modport master (output start, a, b, input busy, done, product);
    modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/seq_mult_ctrl.sv
// Sequencing FSM and multiplier bit counter for seq_mult.
// With SEQ_MULT_SIGNED_EN an extra FIX cycle precedes DONE for sign correction.
module seq_mult_ctrl
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_start,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_capture,
    output logic                     o_step,
    output logic                     o_load,
    output logic [$clog2(WIDTH)-1:0] o_count
);

    localparam int unsigned CW = $clog2(WIDTH);

    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_count;
    logic          w_last_bit;

    assign w_last_bit = (r_count == CW'(WIDTH - 1));
    assign o_count    = r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: if (i_start) w_state_next = ST_RUN;
`ifdef SEQ_MULT_SIGNED_EN
            ST_RUN:  if (w_last_bit) w_state_next = ST_FIX;
            ST_FIX:  w_state_next = ST_DONE;
`else
            ST_RUN:  if (w_last_bit) w_state_next = ST_DONE;
`endif
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // o_load marks the edge on which the final product is registered, so it
    // is visible in the DONE cycle itself.
    always_comb begin
        o_busy    = 1'b0;
        o_done    = 1'b0;
        o_capture = 1'b0;
        o_step    = 1'b0;
        o_load    = 1'b0;
        unique case (r_state)
            ST_IDLE: o_capture = i_start;
            ST_RUN: begin
                o_busy = 1'b1;
                o_step = 1'b1;
`ifndef SEQ_MULT_SIGNED_EN
                o_load = w_last_bit;
`endif
            end
`ifdef SEQ_MULT_SIGNED_EN
            ST_FIX: begin
                o_busy = 1'b1;
                o_load = 1'b1;
            end
`endif
            ST_DONE: o_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (o_capture) begin
            r_count <= '0;
        end else if (o_step) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/seq_mult.sv
// Shift-and-add sequential multiplier, one multiplier bit per cycle, LSB first.
// Define SEQ_MULT_SIGNED_EN for two's-complement operands (magnitude multiply + FIX negate).
module seq_mult
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic      CLOCK_50,
    input  logic      RST_N,
    seq_mult_if.slave bus
);

    localparam int unsigned CW = $clog2(WIDTH);

    generate
        if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
            $error("seq_mult: WIDTH outside legal range");
        end
    endgenerate

    logic               w_busy;
    logic               w_done;
    logic               w_capture;
    logic               w_step;
    logic               w_load;
    logic [CW-1:0]      w_count;

    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_product;
    logic [WIDTH-1:0]   w_mcand_in;
    logic [WIDTH-1:0]   w_mplier_in;
    logic [2*WIDTH-1:0] w_addend;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [2*WIDTH-1:0] w_result;

    seq_mult_ctrl #(
        .WIDTH (WIDTH)
    ) u_ctrl (
        .i_clk     (CLOCK_50),
        .i_rst_n   (RST_N),
        .i_start   (bus.start),
        .o_busy    (w_busy),
        .o_done    (w_done),
        .o_capture (w_capture),
        .o_step    (w_step),
        .o_load    (w_load),
        .o_count   (w_count)
    );

`ifdef SEQ_MULT_SIGNED_EN
    logic r_neg;

    // Magnitudes are multiplied unsigned; -2^(WIDTH-1) maps onto itself as an
    // unsigned value, which is exactly its magnitude.
    assign w_mcand_in  = bus.a[WIDTH-1] ? -bus.a : bus.a;
    assign w_mplier_in = bus.b[WIDTH-1] ? -bus.b : bus.b;
    assign w_result    = r_neg ? -r_acc : r_acc;

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            r_neg <= 1'b0;
        end else if (w_capture) begin
            r_neg <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
        end
    end
`else
    assign w_mcand_in  = bus.a;
    assign w_mplier_in = bus.b;
    assign w_result    = w_acc_next;
`endif

    assign w_addend   = r_mplier[w_count] ? ({{WIDTH{1'b0}}, r_mcand} << w_count) : '0;
    assign w_acc_next = r_acc + w_addend;

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_product <= '0;
        end else begin
            if (w_capture) begin
                r_mcand  <= w_mcand_in;
                r_mplier <= w_mplier_in;
                r_acc    <= '0;
            end else if (w_step) begin
                r_acc <= w_acc_next;
            end
            if (w_load) begin
                r_product <= w_result;
            end
        end
    end

    assign bus.busy    = w_busy;
    assign bus.done    = w_done;
    assign bus.product = r_product;

endmodule

// File: doc/seq_mult.md
SEQ_MULT -- requirements
Module: seq_mult

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the operand width in bits; legal range 2..16.
REQ-002 Port CLOCK_50  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port RST_N  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 Port start  input  1  SHALL request a multiply; sampled only in IDLE.
REQ-005 Port a  input  WIDTH  SHALL be the multiplicand; captured on the accepting edge.
REQ-006 Port b  input  WIDTH  SHALL be the multiplier; captured on the accepting edge.
REQ-007 Port busy  output  1  SHALL be high while an operation is in progress.
REQ-008 Port done  output  1  SHALL be a one-cycle pulse marking a new valid product.
REQ-009 Port product  output  2*WIDTH  SHALL be the registered result of the last completed operation.

Function
REQ-010 FSM states SHALL be IDLE, RUN, FIX and DONE; FIX exists only when SEQ_MULT_SIGNED_EN is defined.
REQ-011 IDLE with start=1 at a rising edge SHALL capture a and b, clear the accumulator and bit counter, and go to RUN.
REQ-012 RUN SHALL run for exactly WIDTH cycles, one multiplier bit per cycle, LSB first: if the bit is 1, acc += multiplicand << count.
REQ-013 Accumulator width SHALL be 2*WIDTH; no overflow is possible and none SHALL be flagged.
REQ-014 After the WIDTH-th RUN cycle, the FSM SHALL go to DONE (unsigned build) or FIX (signed build).
REQ-015 DONE SHALL load product, assert done for exactly one cycle, then return to IDLE.
REQ-016 Unsigned latency: start accepted at edge k -> done and the new product visible in the cycle after edge k+WIDTH.
REQ-017 busy SHALL be high in RUN and FIX and low in IDLE and DONE.
REQ-018 start SHALL be ignored in RUN, FIX and DONE; no queuing.
REQ-019 product SHALL hold its value between DONE cycles; a and b changing after capture SHALL NOT affect the result.
REQ-020 A zero operand SHALL still take the full WIDTH RUN cycles (no early exit).

Reset
REQ-021 RST_N low SHALL immediately force state=IDLE, busy=0, done=0, product=0, acc=0, counter=0, regardless of the clock.
REQ-022 Reset during RUN or FIX SHALL abort the operation; no done pulse follows, and product reads 0.
REQ-023 After RST_N deasserts, the first start SHALL be accepted on the next rising edge.

Configuration
REQ-024 Macro SEQ_MULT_SIGNED_EN SHALL select the operand interpretation.
REQ-025 Without SEQ_MULT_SIGNED_EN: a and b are unsigned, and product = a*b.
REQ-026 With SEQ_MULT_SIGNED_EN: a and b are two's complement, and the magnitudes are captured on the accepting edge.
REQ-027 With SEQ_MULT_SIGNED_EN, FIX SHALL negate acc when the operand signs differ, adding one cycle of latency (done after edge k+WIDTH+1).
REQ-028 With SEQ_MULT_SIGNED_EN, the most-negative operand SHALL be handled as its unsigned magnitude 2^(WIDTH-1), giving the exact product.

Structure
REQ-029 Package seq_mult_pkg SHALL hold the FSM state encodings and the WIDTH legality limits.
REQ-030 The FSM and counter SHALL live in sub-module seq_mult_ctrl; the datapath stays in seq_mult.

Verification
REQ-031 WIDTH=4, unsigned, a=15, b=15, start pulsed at edge k -> busy high for 4 cycles; done=1 with product=8'hE1 (225) in the cycle after edge k+4.
REQ-032 WIDTH=4, a=0, b=9 -> full 4 busy cycles, then product=0 with a single done pulse.
REQ-033 WIDTH=4, a=3, b=5, start held high throughout, with a and b changed mid-RUN -> exactly one product=15 per accepted operation; the next start is accepted only after DONE.
REQ-034 RST_N pulsed low mid-RUN -> busy, done and product are 0 immediately; no done pulse follows.
REQ-035 WIDTH=4, SEQ_MULT_SIGNED_EN, a=-3 (4'hD), b=5 -> done after edge k+5 with product=8'hF1 (-15).
REQ-036 WIDTH=4, SEQ_MULT_SIGNED_EN, a=-8, b=-8 -> product=8'h40 (64).
